// File: rtl/sequenciador_operandos_ula.sv
// ----------------------------------------------------------------------------
// sequenciador_operandos_ula
//
// Sequential front-end for the external combinational 4-bit ALU. It accepts one
// command per valid/ready handshake and registers the opcode and operands onto
// the ALU inputs. One cycle later it captures the ALU result into a result
// register and an accumulator, then holds the result on a valid/ready output
// until the consumer takes it. Operand A can be taken from the accumulator, so
// multi-step computations can be chained.
//
// Ports:
//   clk, rst             single clock; synchronous active-high reset
//   in_valid/in_ready    command handshake
//   in_op, in_a, in_b    opcode and operands
//   in_use_acc           1: operand A comes from acc and in_a is ignored
//   seletor, a, b        registered ALU inputs
//   s                    combinational ALU result
//   out_valid/out_ready  result handshake
//   out_s                registered result
//   acc                  accumulator (last completed result)
//   out_zero, acc_zero   zero flags for out_s / acc (FLAG_ZERO_EN builds only)
//
// Build option: define FLAG_ZERO_EN to add the out_zero and acc_zero ports.
// ----------------------------------------------------------------------------
module sequenciador_operandos_ula #(
    parameter int unsigned LARGURA = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [LARGURA-1:0] in_a,
    input  logic [LARGURA-1:0] in_b,
    input  logic               in_use_acc,
    output logic [2:0]         seletor,
    output logic [LARGURA-1:0] a,
    output logic [LARGURA-1:0] b,
    input  logic [LARGURA-1:0] s,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LARGURA-1:0] out_s,
`ifdef FLAG_ZERO_EN
    output logic               out_zero,
    output logic               acc_zero,
`endif
    output logic [LARGURA-1:0] acc
);

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    state_e             state_q, state_d;
    logic [2:0]         seletor_q, seletor_d;
    logic [LARGURA-1:0] a_q, a_d;
    logic [LARGURA-1:0] b_q, b_d;
    logic [LARGURA-1:0] out_s_q, out_s_d;
    logic [LARGURA-1:0] acc_q, acc_d;
`ifdef FLAG_ZERO_EN
    logic               zero_q, zero_d;
`endif

    // Handshake outputs decode the state register only; rst also masks in_ready
    // so nothing looks acceptable while reset is asserted.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StHold);

    always_comb begin
        state_d   = state_q;
        seletor_d = seletor_q;
        a_d       = a_q;
        b_d       = b_q;
        out_s_d   = out_s_q;
        acc_d     = acc_q;
`ifdef FLAG_ZERO_EN
        zero_d    = zero_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    seletor_d = in_op;
                    b_d       = in_b;
                    // acc here is the previous completed result
                    a_d       = in_use_acc ? acc_q : in_a;
                    state_d   = StExec;
                end
            end
            StExec: begin
                out_s_d = s;
                acc_d   = s;
`ifdef FLAG_ZERO_EN
                zero_d  = (s == '0);
`endif
                state_d = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            seletor_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            out_s_q   <= '0;
            acc_q     <= '0;
`ifdef FLAG_ZERO_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            seletor_q <= seletor_d;
            a_q       <= a_d;
            b_q       <= b_d;
            out_s_q   <= out_s_d;
            acc_q     <= acc_d;
`ifdef FLAG_ZERO_EN
            zero_q    <= zero_d;
`endif
        end
    end

    assign seletor = seletor_q;
    assign a       = a_q;
    assign b       = b_q;
    assign out_s   = out_s_q;
    assign acc     = acc_q;
`ifdef FLAG_ZERO_EN
    // out_s and acc are always loaded together, so one flag serves both.
    assign out_zero = zero_q;
    assign acc_zero = zero_q;
`endif

endmodule
